// File: rtl/param_pipe_adder_tree_pkg.sv
// param_pipe_adder_tree_pkg: width helpers and saturation bounds shared by the adder tree.
package param_pipe_adder_tree_pkg;
    localparam int MAX_W = 128;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int level_n(input int n, input int k);
        int r = n;
        for (int i = 0; i < k; i++) r = (r + 1) / 2;
        return r;
    endfunction
    function automatic int sum_w(input int dw, input int n);
        return dw + clog2(n);
    endfunction
    // Bounds are two's-complement in MAX_W bits so one signed compare covers both modes.
    function automatic logic [MAX_W-1:0] sat_hi(input int w, input logic sgn);
        return sgn ? (MAX_W'(1) << (w - 1)) - MAX_W'(1) : (MAX_W'(1) << w) - MAX_W'(1);
    endfunction
    function automatic logic [MAX_W-1:0] sat_lo(input int w, input logic sgn);
        return sgn ? MAX_W'(0) - (MAX_W'(1) << (w - 1)) : MAX_W'(0);
    endfunction
endpackage

// File: rtl/param_pipe_adder_tree_if.sv
// param_pipe_adder_tree_if: operand input and narrowed-sum output handshakes.
interface param_pipe_adder_tree_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 9,
    parameter int OUT_WIDTH = 32
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic out_overflow;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, out_ready,
        input in_ready, out_data, out_overflow, out_valid
    );
    modport slave (
        input in_data, in_valid, out_ready,
        output in_ready, out_data, out_overflow, out_valid
    );
endinterface

// File: rtl/param_pipe_adder_tree_level.sv
// param_pipe_adder_tree_level: one registered tree level, pairwise add with odd pass-through.
module param_pipe_adder_tree_level #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic valid_i,
    input  logic [N*W-1:0] data_i,
    output logic valid_o,
    output logic [((N+1)/2)*W-1:0] data_o
);
    localparam int M = (N + 1) / 2;
    logic [M*W-1:0] data_d, data_q;
    logic valid_q;
    for (genvar j = 0; j < M; j++) begin : g_pair
        if (2 * j + 1 < N) begin : g_add
            assign data_d[j*W +: W] = data_i[2*j*W +: W] + data_i[(2*j+1)*W +: W];
        end else begin : g_pass
            assign data_d[j*W +: W] = data_i[2*j*W +: W];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else if (en_i) valid_q <= valid_i;
        if (en_i) data_q <= data_d;
    end
    assign valid_o = valid_q;
    assign data_o = data_q;
endmodule

// File: rtl/param_pipe_adder_tree.sv
// param_pipe_adder_tree: pipelined binary adder tree with global stall and
// truncating or saturating narrowing of the full-precision sum.
module param_pipe_adder_tree
    import param_pipe_adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 9,
    parameter int OUT_WIDTH = 32,
    parameter int SIGNED = 1,
    parameter int SATURATE = 0
) (
    input logic clk,
    input logic rst,
    param_pipe_adder_tree_if.slave bus
);
    localparam int LEVELS = clog2(NUM_INPUTS);
    localparam int SUM_W = sum_w(DATA_WIDTH, NUM_INPUTS);
    localparam logic [MAX_W-1:0] HI = sat_hi(OUT_WIDTH, SIGNED != 0);
    localparam logic [MAX_W-1:0] LO = sat_lo(OUT_WIDTH, SIGNED != 0);
    logic [NUM_INPUTS*SUM_W-1:0] ext;
    logic [SUM_W-1:0] tree_data;
    logic tree_valid, advance, over_hi, under_lo, ovf_d;
    logic out_valid_q, out_ovf_q;
    logic [MAX_W-1:0] sum_x;
    logic [OUT_WIDTH-1:0] out_data_d, out_data_q;
    assign advance = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ext
        if (SIGNED != 0) begin : g_s
            assign ext[i*SUM_W +: SUM_W] = SUM_W'($signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]));
        end else begin : g_u
            assign ext[i*SUM_W +: SUM_W] = SUM_W'(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end
    if (LEVELS == 0) begin : g_flat
        assign tree_data = ext;
        assign tree_valid = bus.in_valid;
    end else begin : g_tree
        for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
            localparam int NI = level_n(NUM_INPUTS, k);
            localparam int NO = level_n(NUM_INPUTS, k + 1);
            logic [NI*SUM_W-1:0] din;
            logic [NO*SUM_W-1:0] dout;
            logic vin, vout;
            if (k == 0) begin : g_head
                assign din = ext;
                assign vin = bus.in_valid;
            end else begin : g_link
                assign din = g_lvl[k-1].dout;
                assign vin = g_lvl[k-1].vout;
            end
            param_pipe_adder_tree_level #(.N(NI), .W(SUM_W)) u_level (
                .clk(clk), .rst(rst), .en_i(advance), .valid_i(vin),
                .data_i(din), .valid_o(vout), .data_o(dout)
            );
        end
        assign tree_data = g_lvl[LEVELS-1].dout;
        assign tree_valid = g_lvl[LEVELS-1].vout;
    end
    always_comb begin
        sum_x = (SIGNED != 0) ? MAX_W'($signed(tree_data)) : MAX_W'(tree_data);
        over_hi = $signed(sum_x) > $signed(HI);
        under_lo = $signed(sum_x) < $signed(LO);
        ovf_d = over_hi || under_lo;
        out_data_d = (SATURATE != 0 && ovf_d) ? (over_hi ? HI[OUT_WIDTH-1:0] : LO[OUT_WIDTH-1:0]) : sum_x[OUT_WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ovf_q <= 1'b0;
            out_data_q <= '0;
        end else if (advance) begin
            out_valid_q <= tree_valid;
            out_ovf_q <= ovf_d;
            out_data_q <= out_data_d;
        end
    end
    assign bus.out_valid = out_valid_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_param_pipe_adder_tree.sv
// tb_param_pipe_adder_tree: four configurations driven in lockstep, checked against an arithmetic model.
module tb_param_pipe_adder_tree;
    localparam int N = 9;
    localparam int L = 5;
    typedef logic [N-1:0][31:0] vec_t;
    typedef struct {vec_t v; int cnt;} ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    vec_t ops = '0;
    int passed = 0;
    int total = 0;
    int pops = 0;
    int rdy_low = 0;
    ent_t q[$];
    logic stalled = 1'b0;
    logic [32:0] prev_a = '0;
    always #5 clk = ~clk;
    param_pipe_adder_tree_if #(.DATA_WIDTH(32), .NUM_INPUTS(N), .OUT_WIDTH(32)) ia ();
    param_pipe_adder_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(N), .OUT_WIDTH(8)) ib ();
    param_pipe_adder_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(N), .OUT_WIDTH(8)) ic ();
    param_pipe_adder_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(N), .OUT_WIDTH(8)) id ();
    assign ia.in_data = ops;
    assign {ia.in_valid, ib.in_valid, ic.in_valid, id.in_valid} = {4{in_valid}};
    assign {ia.out_ready, ib.out_ready, ic.out_ready, id.out_ready} = {4{out_ready}};
    for (genvar g = 0; g < N; g++) begin : g_bytes
        assign ib.in_data[g*8 +: 8] = ops[g][7:0];
        assign ic.in_data[g*8 +: 8] = ops[g][7:0];
        assign id.in_data[g*8 +: 8] = ops[g][7:0];
    end
    param_pipe_adder_tree #(.DATA_WIDTH(32), .NUM_INPUTS(N), .OUT_WIDTH(32), .SIGNED(1), .SATURATE(0))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    param_pipe_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(N), .OUT_WIDTH(8), .SIGNED(1), .SATURATE(1))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    param_pipe_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(N), .OUT_WIDTH(8), .SIGNED(1), .SATURATE(0))
        dut_c (.clk(clk), .rst(rst), .bus(ic));
    param_pipe_adder_tree #(.DATA_WIDTH(8), .NUM_INPUTS(N), .OUT_WIDTH(8), .SIGNED(0), .SATURATE(1))
        dut_d (.clk(clk), .rst(rst), .bus(id));

    // Exact integer sum, then range test and clamp/wrap; result is {overflow, data}.
    function automatic logic [32:0] expect_out(input vec_t v, input int dw, input int ow, input logic sgn, input logic sat);
        longint s = 0;
        longint hi, lo, r;
        logic ovf;
        for (int i = 0; i < N; i++) begin
            longint x = longint'(v[i]) & ((longint'(1) << dw) - 1);
            if (sgn && x[dw-1]) x -= longint'(1) << dw;
            s += x;
        end
        hi = sgn ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
        lo = sgn ? -(longint'(1) << (ow - 1)) : 0;
        ovf = (s > hi) || (s < lo);
        r = (sat && ovf) ? ((s > hi) ? hi : lo) : s;
        return {ovf, 32'(r & ((longint'(1) << ow) - 1))};
    endfunction

    function automatic vec_t fill(input logic [31:0] x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = x;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int mode = int'($urandom_range(0, 3));
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: v[i] = $urandom;
                1: v[i] = 32'($urandom_range(0, 40));
                2: v[i] = 32'hFFFF_FF80 | 32'($urandom_range(0, 127));
                default: v[i] = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_007F;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic ev, adv;
        ev = (q.size() > 0) && (q[0].cnt == L);
        check("out_valid_a", 33'(ia.out_valid), 33'(ev));
        check("out_valid_bcd", 33'({ib.out_valid, ic.out_valid, id.out_valid}), ev ? 33'd7 : 33'd0);
        adv = !ev || out_ready;
        check("in_ready", 33'(ia.in_ready), 33'(adv));
        if (!ia.in_ready) rdy_low++;
        if (ev) begin
            check("sum_a", {ia.out_overflow, ia.out_data}, expect_out(q[0].v, 32, 32, 1'b1, 1'b0));
            check("sum_b", {ib.out_overflow, 24'd0, ib.out_data}, expect_out(q[0].v, 8, 8, 1'b1, 1'b1));
            check("sum_c", {ic.out_overflow, 24'd0, ic.out_data}, expect_out(q[0].v, 8, 8, 1'b1, 1'b0));
            check("sum_d", {id.out_overflow, 24'd0, id.out_data}, expect_out(q[0].v, 8, 8, 1'b0, 1'b1));
        end
        if (stalled) check("stall_hold", {ia.out_overflow, ia.out_data}, prev_a);
        stalled = ev && !out_ready;
        prev_a = {ia.out_overflow, ia.out_data};
        if (rst) begin
            q.delete();
            stalled = 1'b0;
        end else if (adv) begin
            if (ev) begin
                void'(q.pop_front());
                pops++;
            end
            foreach (q[i]) q[i].cnt++;
            if (in_valid) q.push_back('{v: ops, cnt: 1});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic send_one(input vec_t v, output int lat);
        @(posedge clk);
        #1;
        ops = v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ia.out_valid) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ramp;
        int lat, sent, p0, r0;
        logic acc;
        for (int i = 0; i < N; i++) ramp[i] = 32'(i + 1);
        check("pin_ramp", expect_out(ramp, 32, 32, 1'b1, 1'b0), 33'h0_0000_002D);
        check("pin_neg9", expect_out(fill(32'hFFFF_FFFF), 32, 32, 1'b1, 1'b0), 33'h0_FFFF_FFF7);
        check("pin_sat100", expect_out(fill(32'd100), 8, 8, 1'b1, 1'b1), 33'h1_0000_007F);
        check("pin_wrap100", expect_out(fill(32'd100), 8, 8, 1'b1, 1'b0), 33'h1_0000_0084);
        check("pin_u255", expect_out(fill(32'd255), 8, 8, 1'b0, 1'b1), 33'h1_0000_00FF);
        check("pin_u28", expect_out(fill(32'd28), 8, 8, 1'b0, 1'b1), 33'h0_0000_00FC);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 33'(ia.out_valid), 33'd0);
        check("reset_in_ready", 33'(ia.in_ready), 33'd1);

        send_one(ramp, lat);
        check("lat_ramp", 33'(lat), 33'd5);
        check("ramp_a", {ia.out_overflow, ia.out_data}, 33'h0_0000_002D);
        idle(3);
        send_one(fill(32'hFFFF_FFFF), lat);
        check("neg9_a", {ia.out_overflow, ia.out_data}, 33'h0_FFFF_FFF7);
        idle(3);
        send_one(fill(32'd100), lat);
        check("sat100_b", {ib.out_overflow, 24'd0, ib.out_data}, 33'h1_0000_007F);
        check("wrap100_c", {ic.out_overflow, 24'd0, ic.out_data}, 33'h1_0000_0084);
        idle(3);
        send_one(fill(32'd255), lat);
        check("u255_d", {id.out_overflow, 24'd0, id.out_data}, 33'h1_0000_00FF);
        idle(3);
        send_one(fill(32'd28), lat);
        check("u28_d", {id.out_overflow, 24'd0, id.out_data}, 33'h0_0000_00FC);
        idle(3);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            ops = rand_vec();
        end
        idle(10);

        sent = 0;
        acc = 1'b0;
        p0 = pops;
        r0 = rdy_low;
        ops = rand_vec();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (acc) ops = rand_vec();
            out_ready = !(c >= 10 && c < 13);
            in_valid = sent < 20;
            @(negedge clk);
            acc = in_valid && ia.in_ready;
            if (acc) sent++;
        end
        idle(2);
        check("stream_ready_low", 33'(rdy_low - r0), 33'd3);
        check("stream_count", 33'(pops - p0), 33'd20);

        idle(5);
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            ops = rand_vec();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ops = rand_vec();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", 33'(ia.out_valid), 33'd0);
        idle(10);
        ramp = rand_vec();
        send_one(ramp, lat);
        check("lat_after_rst", 33'(lat), 33'd5);
        check("sum_after_rst", {ia.out_overflow, ia.out_data}, expect_out(ramp, 32, 32, 1'b1, 1'b0));
        idle(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
